// File: rtl/uart_rx_fifo.sv
// UART receiver: 16x oversampled, configurable frame format, with a
// first-word-fall-through receive FIFO and sticky overrun flag.
module uart_rx_fifo #(
  parameter int CLOCK_FREQUENCY = 25_000_000,
  parameter int BAUD_RATE       = 9600,
  parameter int DATA_BITS       = 8,
  parameter int PARITY          = 0,
  parameter int STOP_BITS       = 1,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                 clockIN,
  input  logic                 nRxResetIN,
  input  logic                 rxIN,
  input  logic                 rxReadIN,
  output logic                 rxValidOUT,
  output logic [DATA_BITS-1:0] rxDataOUT,
  output logic                 rxParityErrOUT,
  output logic                 rxFrameErrOUT,
  output logic                 rxOverrunOUT,
  output logic                 rxIdleOUT
);

  localparam int TICK_DIV = (BAUD_RATE > 0) ? CLOCK_FREQUENCY / (BAUD_RATE * 16) : 0;
  localparam int DIV_W    = (TICK_DIV >= 2) ? $clog2(TICK_DIV) : 1;
  localparam int AW       = (FIFO_DEPTH >= 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int WORD_W   = DATA_BITS + 2;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  if (TICK_DIV < 2) begin : g_bad_tick
    $error("uart_rx_fifo: CLOCK_FREQUENCY/(BAUD_RATE*16) must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
    $error("uart_rx_fifo: DATA_BITS must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_rx_fifo: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_rx_fifo: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_rx_fifo: FIFO_DEPTH must be a power of 2, at least 2");
  end

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  logic                 rx_meta, rx_s, rx_prev;
  logic [2:0]           state;
  logic [DIV_W-1:0]     div_cnt;
  logic [3:0]           tick_cnt;
  logic [3:0]           bit_cnt;
  logic                 samp7, samp8;
  logic [DATA_BITS-1:0] shift;
  logic                 par_err, frame_err;
  logic                 tick, start_edge, decide, bit_val;
  logic                 push, push_ok, pop, full, empty;
  logic [WORD_W-1:0]    push_word, head_next;
  logic [AW:0]          wr_ptr, rd_ptr, wr_next, rd_next;
  logic [WORD_W-1:0]    mem [FIFO_DEPTH];

  assign tick       = (div_cnt == DIV_LAST);
  assign start_edge = (state == S_IDLE) && rx_prev && !rx_s;
  assign decide     = tick && (tick_cnt == 4'd9) && (state != S_IDLE);
  assign bit_val    = maj3(samp7, samp8, rx_s);

  // The word is pushed on the last stop-bit decision, not at the end of the stop bit
  assign push      = decide && (state == S_STOP) && (bit_cnt == 4'(STOP_BITS - 1));
  assign push_word = {frame_err | !bit_val, par_err, shift};

  always_ff @(posedge clockIN) begin
    if (!nRxResetIN) begin
      rx_meta   <= 1'b1;
      rx_s      <= 1'b1;
      rx_prev   <= 1'b1;
      state     <= S_IDLE;
      div_cnt   <= '0;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      par_err   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_meta <= rxIN;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
      if (start_edge) begin
        state     <= S_START;
        div_cnt   <= '0;
        tick_cnt  <= '0;
        bit_cnt   <= '0;
        par_err   <= 1'b0;
        frame_err <= 1'b0;
      end else begin
        div_cnt <= tick ? '0 : div_cnt + 1'b1;
        if (tick) tick_cnt <= tick_cnt + 4'd1;
        if (decide) begin
          case (state)
            S_START: state <= bit_val ? S_IDLE : S_DATA;
            S_DATA: begin
              if (bit_cnt == 4'(DATA_BITS - 1)) begin
                bit_cnt <= '0;
                state   <= (PARITY != 0) ? S_PARITY : S_STOP;
              end else begin
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
            S_PARITY: begin
              par_err <= ((^shift) ^ bit_val) != (PARITY == 1);
              state   <= S_STOP;
            end
            S_STOP: begin
              if (!bit_val) frame_err <= 1'b1;
              if (bit_cnt == 4'(STOP_BITS - 1)) begin
                bit_cnt <= '0;
                state   <= S_IDLE;
              end else begin
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
            default: state <= S_IDLE;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clockIN) begin
    if (tick && tick_cnt == 4'd7) samp7 <= rx_s;
    if (tick && tick_cnt == 4'd8) samp8 <= rx_s;
    if (decide && state == S_DATA) shift <= {bit_val, shift[DATA_BITS-1:1]};
    if (push_ok) mem[wr_ptr[AW-1:0]] <= push_word;
  end

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop     = !empty && rxReadIN;
  assign push_ok = push && (!full || pop);
  assign wr_next = push_ok ? wr_ptr + 1'b1 : wr_ptr;
  assign rd_next = pop ? rd_ptr + 1'b1 : rd_ptr;

  // A word written into the slot that becomes the head must bypass the array
  assign head_next = (push_ok && wr_ptr[AW-1:0] == rd_next[AW-1:0]) ? push_word
                                                                     : mem[rd_next[AW-1:0]];

  always_ff @(posedge clockIN) begin
    if (!nRxResetIN) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      rxOverrunOUT   <= 1'b0;
      rxDataOUT      <= '0;
      rxParityErrOUT <= 1'b0;
      rxFrameErrOUT  <= 1'b0;
    end else begin
      wr_ptr <= wr_next;
      rd_ptr <= rd_next;
      if (push && full && !pop) rxOverrunOUT <= 1'b1;
      else if (pop) rxOverrunOUT <= 1'b0;
      if (wr_next != rd_next) begin
        {rxFrameErrOUT, rxParityErrOUT, rxDataOUT} <= head_next;
      end
    end
  end

  assign rxValidOUT = !empty;
  assign rxIdleOUT  = (state == S_IDLE);

endmodule
